// File: rtl/mux_share_arbiter.sv
// Round-robin time-slice arbiter sharing one registered 2-to-1 mux path between
// requesters X and Y, with synchronised switch requests and a per-grant slice limit.
module mux_share_arbiter #(
    parameter int WIDTH        = 3,
    parameter int SLICE_CYCLES = 50_000_000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             REQ_X,
    input  logic             REQ_Y,
    input  logic [WIDTH-1:0] DATA_X,
    input  logic [WIDTH-1:0] DATA_Y,
    output logic             GNT_X,
    output logic             GNT_Y,
    output logic             SEL,
    output logic [WIDTH-1:0] M,
    output logic             HANDOVER
);

    localparam int CNT_W = (SLICE_CYCLES > 1) ? $clog2(SLICE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_X = 2'd1,
        ST_GRANT_Y = 2'd2
    } state_t;

    typedef enum logic {
        SERVED_X = 1'b0,
        SERVED_Y = 1'b1
    } served_t;

    logic [SYNC_STAGES-1:0] sync_x_q, sync_x_d;
    logic [SYNC_STAGES-1:0] sync_y_q, sync_y_d;
    logic                   rx, ry;

    state_t                 state_q, state_d;
    served_t                last_served_q, last_served_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sel_q, sel_d;
    logic [WIDTH-1:0]       m_q, m_d;
    logic                   handover_q, handover_d;

    logic                   expire;
    logic                   entry;

    // Requests come from raw switches; shift them through a flop chain before use.
    always_comb begin
        sync_x_d = {sync_x_q[SYNC_STAGES-2:0], REQ_X};
        sync_y_d = {sync_y_q[SYNC_STAGES-2:0], REQ_Y};
    end

    assign rx     = sync_x_q[SYNC_STAGES-1];
    assign ry     = sync_y_q[SYNC_STAGES-1];
    assign expire = (cnt_q == CNT_LAST);

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        cnt_d         = '0;
        sel_d         = sel_q;
        m_d           = '0;
        handover_d    = 1'b0;
        entry         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx && (!ry || last_served_q == SERVED_Y)) begin
                    state_d = ST_GRANT_X;
                end else if (ry) begin
                    state_d = ST_GRANT_Y;
                end
            end
            ST_GRANT_X: begin
                // Release takes precedence over expiry; both lead to the same place.
                if (!rx) begin
                    state_d = ry ? ST_GRANT_Y : ST_IDLE;
                end else if (expire && ry) begin
                    state_d = ST_GRANT_Y;
                end
            end
            ST_GRANT_Y: begin
                if (!ry) begin
                    state_d = rx ? ST_GRANT_X : ST_IDLE;
                end else if (expire && rx) begin
                    state_d = ST_GRANT_X;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        entry = (state_d != state_q) && (state_d != ST_IDLE);

        // A held grant with nobody waiting just restarts its slice silently.
        if (state_d == state_q && state_q != ST_IDLE) begin
            cnt_d = expire ? '0 : cnt_q + CNT_W'(1);
        end

        if (entry) begin
            last_served_d = (state_d == ST_GRANT_X) ? SERVED_X : SERVED_Y;
        end

        case (state_d)
            ST_GRANT_X: begin
                sel_d = 1'b0;
                m_d   = DATA_X;
            end
            ST_GRANT_Y: begin
                sel_d = 1'b1;
                m_d   = DATA_Y;
            end
            default: begin
                sel_d = sel_q;
                m_d   = '0;
            end
        endcase

        handover_d = entry;
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_x_q      <= '0;
            sync_y_q      <= '0;
            state_q       <= ST_IDLE;
            last_served_q <= SERVED_Y;
            cnt_q         <= '0;
            sel_q         <= 1'b0;
            m_q           <= '0;
            handover_q    <= 1'b0;
        end else begin
            sync_x_q      <= sync_x_d;
            sync_y_q      <= sync_y_d;
            state_q       <= state_d;
            last_served_q <= last_served_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            m_q           <= m_d;
            handover_q    <= handover_d;
        end
    end

    assign GNT_X    = (state_q == ST_GRANT_X);
    assign GNT_Y    = (state_q == ST_GRANT_Y);
    assign SEL      = sel_q;
    assign M        = m_q;
    assign HANDOVER = handover_q;

`ifndef SYNTHESIS
    a_grant_exclusive : assert property (@(posedge CLOCK_50) disable iff (!RESET_N)
        !(GNT_X && GNT_Y));
`endif

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed bench for mux_share_arbiter: a vector table for the main sequences,
// plus hand-written async-reset and single-cycle-slice sequences.
module tb_mux_share_arbiter;

    localparam int WIDTH = 3;

    logic             clk;
    logic             rst_n;
    logic             req_x, req_y;
    logic [WIDTH-1:0] data_x, data_y;
    logic             gnt_x, gnt_y, sel, handover;
    logic [WIDTH-1:0] m;

    logic             req_x1, req_y1;
    logic [WIDTH-1:0] data_x1, data_y1;
    logic             gnt_x1, gnt_y1, sel1, handover1;
    logic [WIDTH-1:0] m1;

    int n_checks = 0;
    int n_pass   = 0;

    mux_share_arbiter #(.WIDTH(WIDTH), .SLICE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .REQ_X    (req_x),
        .REQ_Y    (req_y),
        .DATA_X   (data_x),
        .DATA_Y   (data_y),
        .GNT_X    (gnt_x),
        .GNT_Y    (gnt_y),
        .SEL      (sel),
        .M        (m),
        .HANDOVER (handover)
    );

    mux_share_arbiter #(.WIDTH(WIDTH), .SLICE_CYCLES(1), .SYNC_STAGES(2)) dut1 (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .REQ_X    (req_x1),
        .REQ_Y    (req_y1),
        .DATA_X   (data_x1),
        .DATA_Y   (data_y1),
        .GNT_X    (gnt_x1),
        .GNT_Y    (gnt_y1),
        .SEL      (sel1),
        .M        (m1),
        .HANDOVER (handover1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst_n;
        logic             req_x;
        logic             req_y;
        logic [WIDTH-1:0] dx;
        logic [WIDTH-1:0] dy;
        logic             gx;
        logic             gy;
        logic             sel;
        logic [WIDTH-1:0] m;
        logic             ho;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input logic r, input logic x, input logic y,
                       input logic [WIDTH-1:0] dx, input logic [WIDTH-1:0] dy,
                       input logic gx, input logic gy, input logic s,
                       input logic [WIDTH-1:0] mm, input logic ho);
        vec_t v;
        v.rst_n = r;  v.req_x = x;  v.req_y = y;  v.dx = dx;  v.dy = dy;
        v.gx = gx;    v.gy = gy;    v.sel = s;    v.m = mm;   v.ho = ho;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        req_x   = 1'b0;
        req_y   = 1'b0;
        data_x  = 3'b101;
        data_y  = 3'b010;
        req_x1  = 1'b0;
        req_y1  = 1'b0;
        data_x1 = 3'b011;
        data_y1 = 3'b100;

        // X alone: 3-cycle latency, then a long hold whose slice wraps silently.
        add(0, 0, 0, 3'b101, 3'b010, 0, 0, 0, 3'b000, 0);
        add(1, 1, 0, 3'b101, 3'b010, 0, 0, 0, 3'b000, 0);
        add(1, 1, 0, 3'b101, 3'b010, 0, 0, 0, 3'b000, 0);
        add(1, 1, 0, 3'b101, 3'b010, 1, 0, 0, 3'b101, 1);
        for (int i = 0; i < 12; i++) begin
            add(1, 1, 0, 3'(i), 3'b010, 1, 0, 0, 3'(i), 0);
        end
        // X releases while Y asks: Y granted 3 cycles later, then both drop to idle.
        add(1, 0, 1, 3'b101, 3'b010, 1, 0, 0, 3'b101, 0);
        add(1, 0, 1, 3'b101, 3'b010, 1, 0, 0, 3'b101, 0);
        add(1, 0, 1, 3'b101, 3'b010, 0, 1, 1, 3'b010, 1);
        add(1, 0, 1, 3'b101, 3'b010, 0, 1, 1, 3'b010, 0);
        add(1, 0, 0, 3'b101, 3'b010, 0, 1, 1, 3'b010, 0);
        add(1, 0, 0, 3'b101, 3'b010, 0, 1, 1, 3'b010, 0);
        add(1, 0, 0, 3'b101, 3'b010, 0, 0, 1, 3'b000, 0);
        add(1, 0, 0, 3'b101, 3'b010, 0, 0, 1, 3'b000, 0);
        // Reset, then simultaneous requests: X first, 4-cycle slices alternate.
        add(0, 0, 0, 3'b101, 3'b110, 0, 0, 0, 3'b000, 0);
        add(1, 1, 1, 3'b101, 3'b110, 0, 0, 0, 3'b000, 0);
        add(1, 1, 1, 3'b101, 3'b110, 0, 0, 0, 3'b000, 0);
        add(1, 1, 1, 3'b101, 3'b110, 1, 0, 0, 3'b101, 1);
        for (int i = 0; i < 3; i++) add(1, 1, 1, 3'b101, 3'b110, 1, 0, 0, 3'b101, 0);
        add(1, 1, 1, 3'b101, 3'b110, 0, 1, 1, 3'b110, 1);
        for (int i = 0; i < 3; i++) add(1, 1, 1, 3'b101, 3'b110, 0, 1, 1, 3'b110, 0);
        add(1, 1, 1, 3'b101, 3'b110, 1, 0, 0, 3'b101, 1);

        #1;
        foreach (vecs[i]) begin
            rst_n  = vecs[i].rst_n;
            req_x  = vecs[i].req_x;
            req_y  = vecs[i].req_y;
            data_x = vecs[i].dx;
            data_y = vecs[i].dy;
            tick();
            check($sformatf("row%0d gnt_x", i), 32'(gnt_x), 32'(vecs[i].gx));
            check($sformatf("row%0d gnt_y", i), 32'(gnt_y), 32'(vecs[i].gy));
            check($sformatf("row%0d sel", i), 32'(sel), 32'(vecs[i].sel));
            check($sformatf("row%0d m", i), 32'(m), 32'(vecs[i].m));
            check($sformatf("row%0d handover", i), 32'(handover), 32'(vecs[i].ho));
            check($sformatf("row%0d overlap", i), 32'(gnt_x & gnt_y), 32'(0));
        end

        // Run X's slice out so Y holds the path, then pull reset between edges.
        repeat (4) tick();
        check("pre_reset gnt_y", 32'(gnt_y), 32'(1));
        check("pre_reset sel", 32'(sel), 32'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset gnt_x", 32'(gnt_x), 32'(0));
        check("async_reset gnt_y", 32'(gnt_y), 32'(0));
        check("async_reset sel", 32'(sel), 32'(0));
        check("async_reset m", 32'(m), 32'(0));
        check("async_reset handover", 32'(handover), 32'(0));
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("post_reset idle gnt_x", 32'(gnt_x), 32'(0));
        check("post_reset idle gnt_y", 32'(gnt_y), 32'(0));
        tick();
        check("post_reset gnt_x", 32'(gnt_x), 32'(1));
        check("post_reset gnt_y", 32'(gnt_y), 32'(0));
        check("post_reset handover", 32'(handover), 32'(1));

        // Single-cycle slice with both requesters waiting: alternate every cycle.
        req_x1 = 1'b1;
        req_y1 = 1'b1;
        repeat (2) tick();
        check("slice1 idle gnt_x", 32'(gnt_x1), 32'(0));
        check("slice1 idle gnt_y", 32'(gnt_y1), 32'(0));
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("slice1 c%0d gnt_x", k), 32'(gnt_x1), 32'((k % 2) == 0));
            check($sformatf("slice1 c%0d gnt_y", k), 32'(gnt_y1), 32'((k % 2) == 1));
            check($sformatf("slice1 c%0d sel", k), 32'(sel1), 32'(k % 2));
            check($sformatf("slice1 c%0d m", k), 32'(m1), ((k % 2) == 0) ? 32'h3 : 32'h4);
            check($sformatf("slice1 c%0d handover", k), 32'(handover1), 32'(1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
